// File: rtl/asyn_fifo_read_stream.sv
// Read side of the dual-clock FIFO: write-pointer synchronizer, mirrored Gray read
// pointer for arbitrary depth, RAM read issue and a 2-entry prefetch buffer.
module asyn_fifo_read_stream #(
  parameter int ADDRWIDTH  = 6,
  parameter int FIFODEPTH  = 44,
  parameter int DATAWIDTH  = 32,
  parameter int SYNCSTAGES = 2,
  parameter int AE_THRESH  = 4
) (
  input  logic                 r_clk,
  input  logic                 r_rst_n,
  input  logic [ADDRWIDTH:0]   w2r_ptr_async,
  output logic [ADDRWIDTH:0]   rptr,
  output logic [ADDRWIDTH-1:0] mem_addr,
  output logic                 mem_ren,
  input  logic [DATAWIDTH-1:0] mem_rdata,
  output logic [DATAWIDTH-1:0] r_data,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [ADDRWIDTH:0]   r_count,
  output logic                 r_almost_empty,
  output logic                 r_error,
  input  logic                 r_err_clr
);

  localparam int PW = ADDRWIDTH + 1;
  localparam logic [PW-1:0] MINBIN2  = PW'(2**ADDRWIDTH - FIFODEPTH);
  localparam logic [PW-1:0] MAXBIN2  = PW'(2**ADDRWIDTH + FIFODEPTH - 1);
  localparam logic [PW-1:0] HALF     = PW'(2**ADDRWIDTH);
  localparam logic [PW-1:0] TWO_MIN  = PW'(2 * (2**ADDRWIDTH - FIFODEPTH));
  localparam logic [PW-1:0] DEPTH_P  = PW'(FIFODEPTH);
  localparam logic [PW-1:0] RST_GRAY = MINBIN2 ^ (MINBIN2 >> 1);
  localparam logic [PW+1:0] AE_LIM   = (PW+2)'(AE_THRESH);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Upper mirror maps straight onto the RAM; lower half is offset by MINBIN2.
  function automatic logic [ADDRWIDTH-1:0] addr_of(input logic [PW-1:0] b);
    logic [PW-1:0] a;
    if (b >= HALF) begin
      a = b - HALF;
    end else begin
      a = b - MINBIN2;
    end
    return a[ADDRWIDTH-1:0];
  endfunction

  logic [PW-1:0]        sync_q [SYNCSTAGES];
  logic [PW-1:0]        wbin2_s;
  logic [PW-1:0]        avail_s;
  logic [PW-1:0]        rbin2_q;
  logic [PW-1:0]        rbnext_s;
  logic [PW-1:0]        rptr_q;
  logic [ADDRWIDTH-1:0] mem_addr_q;
  logic                 inflight_q;
  buf_state_e           state_q, state_d;
  logic [DATAWIDTH-1:0] buf0_q, buf0_d;
  logic [DATAWIDTH-1:0] buf1_q, buf1_d;
  logic                 valid_q;
  logic [PW-1:0]        count_q;
  logic                 ae_q, ae_d;
  logic                 err_q, err_d;
  logic                 push_s, pop_s, ren_s;
  logic [1:0]           buf_cnt_s, buf_cnt_d_s;
  logic [2:0]           credit_s;

  // Write-pointer synchronizer; resets to the empty-FIFO pointer so avail is 0 out of reset.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      for (int i = 0; i < SYNCSTAGES; i++) begin
        sync_q[i] <= RST_GRAY;
      end
    end else begin
      sync_q[0] <= w2r_ptr_async;
      for (int i = 1; i < SYNCSTAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Occupancy modulo 2*FIFODEPTH and the next read pointer.
  always_comb begin
    wbin2_s = gray2bin(sync_q[SYNCSTAGES-1]);
    avail_s = wbin2_s - rbin2_q;
    if (wbin2_s < rbin2_q) begin
      avail_s = avail_s - TWO_MIN;
    end else begin
      avail_s = avail_s;
    end
    if (rbin2_q == MAXBIN2) begin
      rbnext_s = MINBIN2;
    end else begin
      rbnext_s = rbin2_q + PW'(1);
    end
  end

  // Read issue: credit covers the buffer slots free after this cycle's pop.
  always_comb begin
    case (state_q)
      ST_EMPTY: buf_cnt_s = 2'd0;
      ST_ONE:   buf_cnt_s = 2'd1;
      ST_TWO:   buf_cnt_s = 2'd2;
      default:  buf_cnt_s = 2'd0;
    endcase
    push_s   = inflight_q;
    pop_s    = valid_q && r_ready;
    credit_s = 3'd2 - {1'b0, buf_cnt_s} - {2'b00, inflight_q} + {2'b00, pop_s};
    ren_s    = r_rst_n && (avail_s != {PW{1'b0}}) && (credit_s != 3'd0);
  end

  // Output buffer next state: buf0 is the head, buf1 the tail when two are held.
  always_comb begin
    state_d = state_q;
    buf0_d  = buf0_q;
    buf1_d  = buf1_q;
    case (state_q)
      ST_EMPTY: begin
        if (push_s) begin
          buf0_d  = mem_rdata;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (push_s && pop_s) begin
          buf0_d = mem_rdata;
        end else if (push_s) begin
          buf1_d  = mem_rdata;
          state_d = ST_TWO;
        end else if (pop_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_TWO: begin
        if (push_s && pop_s) begin
          buf0_d = buf1_q;
          buf1_d = mem_rdata;
        end else if (pop_s) begin
          buf0_d  = buf1_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_TWO;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Status next values; almost-empty counts everything still owed to the consumer.
  always_comb begin
    case (state_d)
      ST_EMPTY: buf_cnt_d_s = 2'd0;
      ST_ONE:   buf_cnt_d_s = 2'd1;
      ST_TWO:   buf_cnt_d_s = 2'd2;
      default:  buf_cnt_d_s = 2'd0;
    endcase
    ae_d = (({2'b00, avail_s} + {{PW{1'b0}}, buf_cnt_d_s}) <= AE_LIM);
    if (avail_s > DEPTH_P) begin
      err_d = 1'b1;
    end else if (r_err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Pointer, buffer and status registers.
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      rbin2_q    <= MINBIN2;
      rptr_q     <= RST_GRAY;
      mem_addr_q <= {ADDRWIDTH{1'b0}};
      inflight_q <= 1'b0;
      state_q    <= ST_EMPTY;
      buf0_q     <= {DATAWIDTH{1'b0}};
      buf1_q     <= {DATAWIDTH{1'b0}};
      valid_q    <= 1'b0;
      count_q    <= {PW{1'b0}};
      ae_q       <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      if (ren_s) begin
        rbin2_q    <= rbnext_s;
        rptr_q     <= bin2gray(rbnext_s);
        mem_addr_q <= addr_of(rbnext_s);
      end
      inflight_q <= ren_s;
      state_q    <= state_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
      valid_q    <= (state_d != ST_EMPTY);
      count_q    <= avail_s - {{(PW-1){1'b0}}, ren_s};
      ae_q       <= ae_d;
      err_q      <= err_d;
    end
  end

  assign rptr           = rptr_q;
  assign mem_addr       = mem_addr_q;
  assign mem_ren        = ren_s;
  assign r_data         = buf0_q;
  assign r_valid        = valid_q;
  assign r_count        = count_q;
  assign r_almost_empty = ae_q;
  assign r_error        = err_q;

endmodule

// File: tb/tb_asyn_fifo_read_stream.sv
// Scoreboard bench for asyn_fifo_read_stream: a behavioural write side and RAM feed
// words, and a negedge monitor compares every transfer and RAM read address.
module tb_asyn_fifo_read_stream;

  localparam int AW   = 6;
  localparam int D    = 44;
  localparam int DW   = 32;
  localparam int SS   = 2;
  localparam int AE   = 4;
  localparam int MINB = 20;
  localparam int MAXB = 107;
  localparam int HALF = 64;

  logic          r_clk = 1'b0;
  logic          r_rst_n;
  logic [AW:0]   w2r_ptr_async;
  logic [AW:0]   rptr;
  logic [AW-1:0] mem_addr;
  logic          mem_ren;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] r_data;
  logic          r_valid;
  logic          r_ready;
  logic [AW:0]   r_count;
  logic          r_almost_empty;
  logic          r_error;
  logic          r_err_clr;

  always #5 r_clk = ~r_clk;

  asyn_fifo_read_stream #(
    .ADDRWIDTH(AW), .FIFODEPTH(D), .DATAWIDTH(DW), .SYNCSTAGES(SS), .AE_THRESH(AE)
  ) dut (
    .r_clk(r_clk), .r_rst_n(r_rst_n), .w2r_ptr_async(w2r_ptr_async), .rptr(rptr),
    .mem_addr(mem_addr), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .r_data(r_data),
    .r_valid(r_valid), .r_ready(r_ready), .r_count(r_count),
    .r_almost_empty(r_almost_empty), .r_error(r_error), .r_err_clr(r_err_clr)
  );

  logic [DW-1:0] ram [0:63];
  always @(posedge r_clk) begin
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge r_clk) cyc <= cyc + 1;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  int            wbin;
  int            n_xfer = 0;
  bit            mon_en = 1'b0;
  int            exp_rbin;
  logic [AW:0]   prev_rptr;
  bit            hold_pend = 1'b0;
  logic [DW-1:0] hold_data;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int nxt(input int p);
    return (p == MAXB) ? MINB : p + 1;
  endfunction

  function automatic int adv(input int p, input int k);
    int q = p;
    for (int i = 0; i < k; i++) q = nxt(q);
    return q;
  endfunction

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic int addr_of(input int b);
    return (b >= HALF) ? b - HALF : b - MINB;
  endfunction

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic write_word(output logic [DW-1:0] d);
    d = $urandom;
    ram[addr_of(wbin)] = d;
    exp_q.push_back(d);
    wbin = nxt(wbin);
    w2r_ptr_async = gray(wbin);
  endtask

  // Monitor step: scoreboard, stall stability, RAM address/pointer model, Gray step.
  task automatic mon_step();
    if (mon_en) begin
      if (hold_pend) begin
        check_eq("hold_valid", r_valid, 1);
        check_eq("hold_data", r_data, hold_data);
      end
      hold_pend = r_valid && !r_ready;
      hold_data = r_data;
      if (rptr !== prev_rptr) begin
        check_eq("rptr_onebit", $countones(rptr ^ prev_rptr), 1);
        prev_rptr = rptr;
      end
      if (mem_ren) begin
        check_eq("mem_addr", mem_addr, addr_of(exp_rbin));
        check_eq("rptr_cur", rptr, gray(exp_rbin));
        exp_rbin = nxt(exp_rbin);
      end
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) check_eq("sb_nonempty", exp_q.size(), 1);
        else check_eq("data", r_data, exp_q.pop_front());
        n_xfer++;
      end
    end
  endtask

  initial forever begin
    @(negedge r_clk);
    mon_step();
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rptr"}, rptr, 7'b0011110);
    check_eq({tag, "_mem_addr"}, mem_addr, 0);
    check_eq({tag, "_mem_ren"}, mem_ren, 0);
    check_eq({tag, "_r_valid"}, r_valid, 0);
    check_eq({tag, "_r_data"}, r_data, 0);
    check_eq({tag, "_r_count"}, r_count, 0);
    check_eq({tag, "_ae"}, r_almost_empty, 1);
    check_eq({tag, "_r_error"}, r_error, 0);
  endtask

  task automatic release_reset();
    r_ready = 1'b0;
    r_err_clr = 1'b0;
    wbin = MINB;
    w2r_ptr_async = gray(MINB);
    tick();
    r_rst_n = 1'b1;
    exp_rbin = MINB;
    prev_rptr = gray(MINB);
    hold_pend = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic drain(input int bound);
    int k = 0;
    r_ready = 1'b1;
    while ((exp_q.size() != 0 || r_valid) && k < bound) begin
      tick();
      k++;
    end
    if (k >= bound) check_eq("drain_timeout", exp_q.size(), 0);
    r_ready = 1'b0;
    tick();
  endtask

  initial begin
    logic [DW-1:0] d, d0;
    int base, sent, t_first, t_last, p, k;
    bit saw0;

    r_rst_n = 1'b0;
    r_ready = 1'b0;
    r_err_clr = 1'b0;
    w2r_ptr_async = '0;
    for (int i = 0; i < 64; i++) ram[i] = $urandom;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      w2r_ptr_async = $urandom;
      r_ready = 1'($urandom_range(0, 1));
      r_err_clr = 1'($urandom_range(0, 1));
      tick();
      check_reset_outputs("rst");
    end
    release_reset();
    check_eq("post_rst_ae", r_almost_empty, 1);
    check_eq("post_rst_ren", mem_ren, 0);

    // Single-word latency
    write_word(d0);
    tick();
    check_eq("lat_ren_e1", mem_ren, 0);
    tick();
    check_eq("lat_ren_e2", mem_ren, 1);
    check_eq("lat_valid_e2", r_valid, 0);
    tick();
    check_eq("lat_valid_e3", r_valid, 0);
    check_eq("lat_count_e3", r_count, 0);
    tick();
    check_eq("lat_valid_e4", r_valid, 1);
    check_eq("lat_data_e4", r_data, d0);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check_eq("lat_valid_pop", r_valid, 0);
    check_eq("lat_count_pop", r_count, 0);
    check_eq("lat_sb_empty", exp_q.size(), 0);

    // Streaming 200 words at full rate
    base = n_xfer;
    for (int i = 0; i < 10; i++) write_word(d);
    sent = 10;
    t_first = -1;
    t_last = -1;
    r_ready = 1'b1;
    k = 0;
    while (n_xfer - base < 200 && k < 2000) begin
      if (sent < 200 && exp_q.size() < D) begin
        write_word(d);
        sent++;
      end
      tick();
      k++;
      if (n_xfer - base == 1 && t_first < 0) t_first = cyc;
      if (n_xfer - base == 200) t_last = cyc;
    end
    check_eq("stream_count", n_xfer - base, 200);
    check_eq("stream_throughput", t_last - t_first, 199);
    drain(50);

    // Random backpressure over 500 words
    base = n_xfer;
    sent = 0;
    k = 0;
    while (n_xfer - base < 500 && k < 6000) begin
      r_ready = 1'($urandom_range(0, 1));
      if (sent < 500 && exp_q.size() < D && $urandom_range(0, 1) == 1) begin
        write_word(d);
        sent++;
      end
      tick();
      k++;
    end
    r_ready = 1'b0;
    check_eq("bp_count", n_xfer - base, 500);
    check_eq("bp_left", exp_q.size(), 0);
    tick();
    for (int i = 0; i < 10; i++) write_word(d);
    repeat (10) tick();
    check_eq("bp_prefetch_count", r_count, 8);
    check_eq("bp_ren_stopped", mem_ren, 0);
    check_eq("bp_valid", r_valid, 1);
    drain(100);

    // Almost-empty with 6 words
    base = n_xfer;
    saw0 = 1'b0;
    r_ready = 1'b1;
    for (int i = 0; i < 6; i++) write_word(d);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!saw0 && r_almost_empty == 1'b0) saw0 = 1'b1;
      if (saw0) check_eq("almost_empty", r_almost_empty, ((6 - (n_xfer - base)) <= AE));
    end
    check_eq("ae_seen_low", saw0, 1);
    check_eq("ae_all_popped", n_xfer - base, 6);
    drain(50);

    // Pointer corruption error
    p = wbin;
    r_ready = 1'b0;
    w2r_ptr_async = gray(adv(p, 50));
    tick();
    tick();
    check_eq("err_e2", r_error, 0);
    tick();
    check_eq("err_e3", r_error, 1);
    tick();
    tick();
    w2r_ptr_async = gray(adv(p, 2));
    repeat (6) tick();
    check_eq("err_sticky", r_error, 1);
    check_eq("err_count_zero", r_count, 0);
    check_eq("err_ren_idle", mem_ren, 0);
    r_err_clr = 1'b1;
    tick();
    check_eq("err_cleared", r_error, 0);
    r_err_clr = 1'b0;
    tick();
    check_eq("err_stays_clear", r_error, 0);

    // Reset mid-operation discards buffered words
    check_eq("mid_valid_before", r_valid, 1);
    mon_en = 1'b0;
    r_rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    release_reset();
    check_eq("midrst_valid_after", r_valid, 0);
    check_eq("midrst_ren_after", mem_ren, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
